// File: rtl/vga_grid_display.sv
// VGA raster generator that scans the occupancy grid memory and paints each cell as a scaled
// grey square, with the robot's cell overlaid in red and a dark-blue border around the grid.
module vga_grid_display #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned GRID_W      = 128,
  parameter int unsigned GRID_H      = 96,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned X_OFFSET    = 64,
  parameter int unsigned Y_OFFSET    = 48,
  parameter int unsigned CELL_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            position_x,
  input  logic [6:0]            position_y,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_enable,
  input  logic [CELL_WIDTH-1:0] mem_data,
  output logic [3:0]            vgaRed,
  output logic [3:0]            vgaGreen,
  output logic [3:0]            vgaBlue,
  output logic                  Hsync,
  output logic                  Vsync,
  output logic                  vga_busy,
  output logic                  frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned GX_W     = $clog2(GRID_W);
  localparam int unsigned GY_W     = ADDR_WIDTH - GX_W;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned X_END    = X_OFFSET + (GRID_W << SCALE_SHIFT);
  localparam int unsigned Y_END    = Y_OFFSET + (GRID_H << SCALE_SHIFT);

  logic [HW-1:0]   h_count;
  logic [VW-1:0]   v_count;
  logic [6:0]      pos_x;
  logic [6:0]      pos_y;
  logic            pos_valid;

  logic            active_c;
  logic            in_grid_c;
  logic            hs_c;
  logic            vs_c;
  logic            origin_c;
  logic            match_c;
  logic [HW-1:0]   h_rel_c;
  logic [VW-1:0]   v_rel_c;
  logic [GX_W-1:0] gx_c;
  logic [GY_W-1:0] gy_c;

  logic            s1_active, s1_hs, s1_vs, s1_origin, s1_match;
  logic            s2_active, s2_hs, s2_vs, s2_origin, s2_match, rd_valid;
  logic [3:0]      grey_c;
  logic [11:0]     rgb_c;

  // Raster counters, advancing every pixel clock
  always_ff @(posedge clock) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == HW'(H_TOTAL - 1)) begin
      h_count <= '0;
      v_count <= (v_count == VW'(V_TOTAL - 1)) ? '0 : v_count + VW'(1);
    end else begin
      h_count <= h_count + HW'(1);
    end
  end

  // Robot position is sampled once per frame so the overlay never tears
  always_ff @(posedge clock) begin
    if (reset) begin
      pos_x     <= '0;
      pos_y     <= '0;
      pos_valid <= 1'b0;
    end else if (origin_c) begin
      pos_x     <= position_x;
      pos_y     <= position_y;
      pos_valid <= (32'(position_x) < GRID_W) && (32'(position_y) < GRID_H);
    end
  end

  always_comb begin
    active_c  = (h_count < HW'(H_ACTIVE)) && (v_count < VW'(V_ACTIVE));
    hs_c      = !((h_count >= HW'(HS_START)) && (h_count < HW'(HS_END)));
    vs_c      = !((v_count >= VW'(VS_START)) && (v_count < VW'(VS_END)));
    origin_c  = (h_count == '0) && (v_count == '0);
    in_grid_c = active_c
             && (h_count >= HW'(X_OFFSET)) && (32'(h_count) < X_END)
             && (v_count >= VW'(Y_OFFSET)) && (32'(v_count) < Y_END);
    h_rel_c   = h_count - HW'(X_OFFSET);
    v_rel_c   = v_count - VW'(Y_OFFSET);
    gx_c      = GX_W'(h_rel_c >> SCALE_SHIFT);
    gy_c      = GY_W'(v_rel_c >> SCALE_SHIFT);
    match_c   = pos_valid && (gx_c == GX_W'(pos_x)) && (gy_c == GY_W'(pos_y));
  end

  // Stages 1 and 2: issue the read, then carry pixel attributes alongside the memory latency
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr        <= '0;
      mem_read_enable <= 1'b0;
      vga_busy        <= 1'b0;
      s1_active       <= 1'b0;
      s1_hs           <= 1'b1;
      s1_vs           <= 1'b1;
      s1_origin       <= 1'b0;
      s1_match        <= 1'b0;
      s2_active       <= 1'b0;
      s2_hs           <= 1'b1;
      s2_vs           <= 1'b1;
      s2_origin       <= 1'b0;
      s2_match        <= 1'b0;
      rd_valid        <= 1'b0;
    end else begin
      if (in_grid_c) begin
        mem_addr <= {gy_c, gx_c};
      end
      mem_read_enable <= in_grid_c;
      vga_busy        <= in_grid_c || mem_read_enable;
      s1_active       <= active_c;
      s1_hs           <= hs_c;
      s1_vs           <= vs_c;
      s1_origin       <= origin_c;
      s1_match        <= match_c;
      s2_active       <= s1_active;
      s2_hs           <= s1_hs;
      s2_vs           <= s1_vs;
      s2_origin       <= s1_origin;
      s2_match        <= s1_match;
      rd_valid        <= mem_read_enable;
    end
  end

  // Pixel colour: blank, border, robot overlay, or inverted occupancy grey
  always_comb begin
    grey_c = 4'hF - 4'(mem_data >> (CELL_WIDTH - 4));
    rgb_c  = 12'h000;
    if (!s2_active) begin
      rgb_c = 12'h000;
    end else if (!rd_valid) begin
      rgb_c = 12'h003;
    end else if (s2_match) begin
      rgb_c = 12'hF00;
    end else begin
      rgb_c = {grey_c, grey_c, grey_c};
    end
  end

  // Stage 3: registered display outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      vgaRed      <= '0;
      vgaGreen    <= '0;
      vgaBlue     <= '0;
      Hsync       <= 1'b1;
      Vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vgaRed      <= rgb_c[11:8];
      vgaGreen    <= rgb_c[7:4];
      vgaBlue     <= rgb_c[3:0];
      Hsync       <= s2_hs;
      Vsync       <= s2_vs;
      frame_start <= s2_origin;
    end
  end

endmodule

// File: tb/tb_vga_grid_display.sv
// Bench for vga_grid_display on a reduced raster so whole frames fit in a short run;
// every output is compared each cycle against an arithmetic pixel model.
module tb_vga_grid_display;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 40, VF = 2, VS = 2, VB = 3;
  localparam int GW = 8, GH = 6, SS = 2, XO = 16, YO = 8, CW = 8, AW = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int CELL = 1 << SS;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    position_x, position_y;
  logic [AW-1:0] mem_addr;
  logic          mem_read_enable;
  logic [CW-1:0] mem_data;
  logic [3:0]    vgaRed, vgaGreen, vgaBlue;
  logic          Hsync, Vsync, vga_busy, frame_start;

  logic [7:0] mem [0:63];
  int fpx [0:3];
  int fpy [0:3];
  int last_addr;
  int cur_x, cur_y;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_grid_display #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .GRID_W(GW), .GRID_H(GH), .SCALE_SHIFT(SS),
    .X_OFFSET(XO), .Y_OFFSET(YO), .CELL_WIDTH(CW), .ADDR_WIDTH(AW)
  ) dut (
    .clock(clk), .reset(reset),
    .position_x(position_x), .position_y(position_y),
    .mem_addr(mem_addr), .mem_read_enable(mem_read_enable), .mem_data(mem_data),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .Hsync(Hsync), .Vsync(Vsync), .vga_busy(vga_busy), .frame_start(frame_start)
  );

  // Synchronous-read grid memory
  always_ff @(posedge clk) begin
    if (mem_read_enable) mem_data <= mem[mem_addr];
  end

  // Pixel index p counts clocks since reset release; negative p means no pixel yet
  function automatic bit grid_px(input int p);
    int h, v;
    if (p < 0) return 1'b0;
    h = p % HT;
    v = (p / HT) % VT;
    return (h < HA) && (v < VA) && (h >= XO) && (h < XO + GW * CELL)
        && (v >= YO) && (v < YO + GH * CELL);
  endfunction

  function automatic int addr_of(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return ((v - YO) / CELL) * GW + (h - XO) / CELL;
  endfunction

  function automatic logic [11:0] exp_rgb(input int p);
    int h, v, f, cx, cy;
    logic [3:0] g;
    if (p < 0) return 12'h000;
    h = p % HT;
    v = (p / HT) % VT;
    f = p / FRAME;
    if (!((h < HA) && (v < VA))) return 12'h000;
    if (!grid_px(p)) return 12'h003;
    cx = (h - XO) / CELL;
    cy = (v - YO) / CELL;
    if (fpx[f] < GW && fpy[f] < GH && fpx[f] == cx && fpy[f] == cy) return 12'hF00;
    g = 4'(15 - int'(mem[cy * GW + cx]) / 16);
    return {g, g, g};
  endfunction

  function automatic logic [1:0] exp_sync(input int p);
    int h, v;
    if (p < 0) return 2'b11;
    h = p % HT;
    v = (p / HT) % VT;
    return {!(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS)};
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_cycle(input int k);
    bit re1, re2;
    re1 = grid_px(k - 1);
    re2 = grid_px(k - 2);
    if (re1) last_addr = addr_of(k - 1);
    chk("rgb", k, 32'({vgaRed, vgaGreen, vgaBlue}), 32'(exp_rgb(k - 3)));
    chk("sync", k, 32'({Hsync, Vsync}), 32'(exp_sync(k - 3)));
    chk("frame_start", k, 32'(frame_start), 32'((k - 3 >= 0) && ((k - 3) % FRAME == 0)));
    chk("mem_addr", k, 32'(mem_addr), 32'(last_addr));
    chk("mem_read_enable", k, 32'(mem_read_enable), 32'(re1));
    chk("vga_busy", k, 32'(vga_busy), 32'(re1 || re2));
  endtask

  // One reset-to-reset run; rst_k >= 0 asserts reset for one cycle at that cycle
  task automatic run_epoch(input int ncyc, input int rst_k);
    int hs_low = 0, vs_low = 0, vs_run = 0, vs_max = 0;
    int fs_cnt = 0, fs_last = 0, kend = 0;
    last_addr = 0;
    for (int k = 0; k < ncyc; k++) begin
      check_cycle(k);
      if (k >= 3 && k < 3 + FRAME) begin
        if (!Hsync) hs_low++;
        if (!Vsync) begin vs_low++; vs_run++; end else vs_run = 0;
        if (vs_run > vs_max) vs_max = vs_run;
      end
      if (frame_start) begin
        if (fs_cnt > 0) chk("frame_period", k, 32'(k - fs_last), 32'(FRAME));
        fs_cnt++;
        fs_last = k;
      end
      if (k == 0) begin cur_x = 5; cur_y = 3; end
      if (k == 1000) begin cur_x = 6; cur_y = 3; end
      if (k >= FRAME && k % 300 == 150) begin
        cur_x = int'($urandom_range(0, 9));
        cur_y = int'($urandom_range(0, 7));
      end
      position_x = 7'(cur_x);
      position_y = 7'(cur_y);
      if (k % FRAME == 0) begin fpx[k / FRAME] = cur_x; fpy[k / FRAME] = cur_y; end
      if (k == 3) chk("first_frame_start", k, 32'(frame_start), 32'd1);
      if (k == 8 * HT + 16 + 3) chk("white_cell0", k, 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0FFF);
      if (k == 8 * HT + 20 + 3) chk("black_cell1", k, 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0000);
      if (k == 8 * HT + 24 + 3) chk("grey_cell2", k, 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0777);
      if (k == 10 * HT + 10 + 3) chk("border", k, 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0003);
      if (k == 10 * HT + 70 + 3) chk("blanking", k, 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0000);
      if (k == 20 * HT + 36 + 3) chk("robot_f0", k, 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0F00);
      if (k == 20 * HT + 40 + 3) chk("no_tear_f0", k, 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0FFF);
      if (k == FRAME + 20 * HT + 36 + 3) chk("old_pos_f1", k, 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0FFF);
      if (k == FRAME + 20 * HT + 40 + 3) chk("robot_f1", k, 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0F00);
      kend = k + 1;
      if (k == rst_k) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    chk("hsync_low_per_frame", kend, 32'(hs_low), 32'(HS * VT));
    chk("vsync_low_total", kend, 32'(vs_low), 32'(VS * HT));
    chk("vsync_low_run", kend, 32'(vs_max), 32'(VS * HT));
    chk("frame_start_count", kend, 32'(fs_cnt), 32'((kend - 1 - 3) / FRAME + 1));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h00;
    mem[1] = 8'hF0;
    mem[2] = 8'h80;
    mem[29] = 8'h00;
    mem[30] = 8'h00;
    cur_x = 0;
    cur_y = 0;
    position_x = '0;
    position_y = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hsync", -1, 32'(Hsync), 32'd1);
    chk("reset_vsync", -1, 32'(Vsync), 32'd1);
    chk("reset_addr", -1, 32'(mem_addr), 32'd0);
    reset = 1'b0;
    run_epoch(2 * FRAME + 20 * HT + 5, 2 * FRAME + 20 * HT);
    run_epoch(FRAME + 2000, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_grid_display.md
Name: vga_grid_display

Overview:
- Downstream display stage of the SLAM top level. It generates 640x480@60 VGA timing on the pixel clock and reads the occupancy grid memory through a synchronous-read port.
- Each grid cell is scaled to a square of 2^SCALE_SHIFT by 2^SCALE_SHIFT pixels, and each cell value is mapped to a grey level.
- The robot's cell is overlaid in red. The block drives vgaRed/Green/Blue, Hsync, Vsync and vga_busy for the control unit.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync lines
- V_BP, 33, vertical back porch
- GRID_W, 128, grid columns; must be a power of 2
- GRID_H, 96, grid rows
- SCALE_SHIFT, 2, log2 of cell size in pixels
- X_OFFSET, 64, first pixel column of the grid
- Y_OFFSET, 48, first line of the grid
- CELL_WIDTH, 8, bits per occupancy cell (unsigned; 0 = free, max = occupied)
- ADDR_WIDTH, 14, memory address width; equals log2(GRID_W)+ceil(log2(GRID_H))

Ports:
- clock  in  1  pixel clock (25 MHz, driven by pxlClk)
- reset  in  1  synchronous, active-high
- position_x  in  7  robot cell column
- position_y  in  7  robot cell row
- mem_addr  out  ADDR_WIDTH  grid read address
- mem_read_enable  out  1  read strobe
- mem_data  in  CELL_WIDTH  read data, valid 1 cycle after the mem_addr/mem_read_enable cycle
- vgaRed  out  4  red channel
- vgaGreen  out  4  green channel
- vgaBlue  out  4  blue channel
- Hsync  out  1  horizontal sync, active low
- Vsync  out  1  vertical sync, active low
- vga_busy  out  1  grid memory read in flight
- frame_start  out  1  one-cycle pulse at output pixel (0,0)

Behaviour:
- Counters:
  - h_count runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. It wraps to 0 and increments v_count.
  - v_count runs 0..V_TOTAL-1, where V_TOTAL = 525, and wraps to 0.
  - Both advance every clock.
- Regions, per counter value:
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - hs_raw low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. vs_raw uses the same rule with the V_ parameters.
  - in_grid = active && X_OFFSET <= h < X_OFFSET+(GRID_W<<SCALE_SHIFT) && Y_OFFSET <= v < Y_OFFSET+(GRID_H<<SCALE_SHIFT).
- Pipeline, 3 stages, with the counter value at cycle t:
  - t+1: mem_addr = {gy, gx} is registered, where gx = (h-X_OFFSET)>>SCALE_SHIFT and gy = (v-Y_OFFSET)>>SCALE_SHIFT. mem_read_enable = in_grid.
    - When not in_grid, mem_addr holds its last value and mem_read_enable = 0.
  - t+2: mem_data is valid.
  - t+3: colour, Hsync, Vsync and frame_start are registered. Sync, active, in_grid and the robot-cell match are delayed 3 cycles so every output stays aligned to the same pixel.
- Colour at output:
  - Blanking (not active): 0,0,0.
  - Active but outside the grid: 0,0,3 (dark blue border).
  - Grid cell matching the latched position: F,0,0.
  - Other grid cells: grey g = 15 - mem_data[CELL_WIDTH-1 -: 4] on all three channels, so free cells are white and occupied cells are black.
- Position latching:
  - position_x/position_y are sampled only when h=0 && v=0 at the counter stage.
  - A mid-frame change takes effect next frame (no tearing).
  - A latched position outside the grid never matches any cell.
- vga_busy = mem_read_enable at stage 1 OR the read-valid flag at stage 2. It goes high 1 cycle after in_grid and low 2 cycles after in_grid falls.
- frame_start pulses when the delayed counter equals (0,0), i.e. once per 420000 cycles.
- Reset, effective the same cycle:
  - h_count = v_count = 0; all pipeline stages cleared.
  - Hsync = Vsync = 1, colours = 0, mem_read_enable = 0, mem_addr = 0, vga_busy = 0, frame_start = 0, latched position = 0.
  - Reset mid-frame aborts the frame. The first frame_start after release occurs 3 cycles after release.
- No write port. The control unit must not modify the grid while vga_busy = 1; this block does not arbitrate.

Test Plan:
- Timing: release reset and run 2 frames -> Hsync low for exactly 96 of every 800 cycles; Vsync low for exactly 1600 consecutive cycles per 420000; frame_start once per 420000 cycles.
- Addressing: counter at (64,48) -> mem_addr=0 with mem_read_enable=1 one cycle later. (68,48) -> addr 1; (64,52) -> addr 128; (575,431) -> addr 12287. (63,48) and (576,48) -> mem_read_enable=0.
- Colour mapping:
  - Memory model returns 0x00 at addr 0 -> output white F,F,F exactly 3 cycles after the counter hits (64,48).
  - 0xF0 -> 0,0,0; 0x80 -> 7,7,7.
  - Border pixel (10,10) -> 0,0,3; blanking -> 0.
- Overlay latching: position=(5,3) at frame start, changed to (6,3) mid-frame -> the 4x4 block at pixels (84..87, 60..63) is red this frame; the block at (88..91) is red only next frame.
- vga_busy envelope: on each grid line it rises 1 cycle after h=64 and falls 2 cycles after h=576; it stays 0 on lines v<48 and v>=432.
- Reset mid-frame: assert reset for 1 cycle at v=200 -> all outputs at reset values the next cycle; frame_start 3 cycles after release; the timing sequence restarts from (0,0).
